// File: rtl/id_ex_forward_reg.sv
// -----------------------------------------------------------------------------
// id_ex_forward_reg
//
// ID/EX pipeline register with the operand-forwarding muxes in front of it.
// In the ID stage, the rs/rt operands are chosen from the register file, the
// EX-stage ALU result or the MEM-stage write-back data. They are then
// registered into EX together with the ID control fields. A branch/jump flush
// or a load-use stall loads a bubble instead. A load-use stall also raises
// if_id_hold so that the PC and IF/ID keep the stalled instruction for one
// cycle. Two saturating counters record how many bubbles each cause inserted.
//
// Ports
//   clk, reset       rising-edge clock; synchronous reset, active-low
//   id_valid         ID stage holds a real instruction
//   rs_data/rt_data  register-file read data
//   ex_result        ALU result of the instruction in EX   (1-step source)
//   mem_result       write-back data of the instr in MEM   (2-step source)
//   ForwardA/B       00 regfile, 01 ex_result, 10 mem_result, 11 regfile
//   LW_Stall, flush  hazard-unit stall request, branch/jump kill
//   id_*             ID control fields and immediate
//   ex_*             registered EX-stage operands and controls
//   if_id_hold       combinational freeze for PC and IF/ID
//   stall_cnt        load-use bubbles inserted (saturating)
//   flush_cnt        flush bubbles inserted (saturating)
// -----------------------------------------------------------------------------
module id_ex_forward_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic              LW_Stall,
  input  logic              flush,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [3:0]        id_alu_op,
  input  logic [ADDR_W-1:0] id_write_addr,
  input  logic [DATA_W-1:0] id_imm,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [3:0]        ex_alu_op,
  output logic [ADDR_W-1:0] ex_write_addr,
  output logic              if_id_hold,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Pipeline register state
  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] op_a_q,       op_a_d;
  logic [DATA_W-1:0] op_b_q,       op_b_d;
  logic [DATA_W-1:0] imm_q,        imm_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic [3:0]        alu_op_q,     alu_op_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

  // Forwarded operands and bubble qualifiers
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              stall_bubble;

  // The reserved code 11 falls through to the register-file value.
  always_comb begin
    fwd_a = rs_data;
    unique case (ForwardA)
      2'b01:   fwd_a = ex_result;
      2'b10:   fwd_a = mem_result;
      default: fwd_a = rs_data;
    endcase
  end

  always_comb begin
    fwd_b = rt_data;
    unique case (ForwardB)
      2'b01:   fwd_b = ex_result;
      2'b10:   fwd_b = mem_result;
      default: fwd_b = rt_data;
    endcase
  end

  // A flush wins over a stall, so a stall only counts when no flush is present.
  assign stall_bubble = LW_Stall & id_valid & ~flush;

  // The hold must not freeze IF/ID while the pipeline is being reset.
  assign if_id_hold = stall_bubble & reset;

  always_comb begin
    // The default is a bubble. The load case below overrides it.
    valid_d      = 1'b0;
    op_a_d       = '0;
    op_b_d       = '0;
    imm_d        = '0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    alu_op_d     = '0;
    write_addr_d = '0;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (flush) begin
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (stall_bubble) begin
      // The forwarded ex_result belongs to the load's address computation.
      // It is dropped here with the bubble.
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      valid_d = id_valid;
      op_a_d  = fwd_a;
      op_b_d  = fwd_b;
      imm_d   = id_imm;
      // Without a real instruction, keep controls quiet so that neither the
      // hazard unit nor memory reacts to it.
      if (id_valid) begin
        reg_write_d  = id_reg_write;
        mem_read_d   = id_mem_read;
        mem_write_d  = id_mem_write;
        alu_op_d     = id_alu_op;
        write_addr_d = id_write_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      imm_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_op_q     <= '0;
      write_addr_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      imm_q        <= imm_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_op_q     <= alu_op_d;
      write_addr_q <= write_addr_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_op_a       = op_a_q;
  assign ex_op_b       = op_b_q;
  assign ex_imm        = imm_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_write_addr = write_addr_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_forward_reg
//
// Testbench for id_ex_forward_reg, built with CNT_W=4 so that counter
// saturation can be reached. A behavioural model predicts the EX-stage
// contents and the counters at every edge. A compare process checks every
// output on each falling edge. Directed steps also check literal values, and
// a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_id_ex_forward_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [DW-1:0] rs_data, rt_data, ex_result, mem_result, id_imm;
  logic [1:0]    ForwardA, ForwardB;
  logic          LW_Stall, flush;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic [3:0]    id_alu_op;
  logic [AW-1:0] id_write_addr;

  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, if_id_hold;
  logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
  logic [3:0]    ex_alu_op;
  logic [AW-1:0] ex_write_addr;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_forward_reg #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .rs_data(rs_data), .rt_data(rt_data),
    .ex_result(ex_result), .mem_result(mem_result),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .LW_Stall(LW_Stall), .flush(flush),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .id_write_addr(id_write_addr), .id_imm(id_imm),
    .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_imm(ex_imm), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_op(ex_alu_op), .ex_write_addr(ex_write_addr),
    .if_id_hold(if_id_hold), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The EX stage is modelled as a record, and the counters as plain integers.
  typedef struct {
    bit          valid, rw, mr, mw;
    bit [DW-1:0] a, b, imm;
    bit [3:0]    alu;
    bit [AW-1:0] wa;
  } ex_t;

  ex_t m_ex;
  int  m_stall = 0;
  int  m_flush = 0;
  bit  started = 0;

  function automatic bit [DW-1:0] pick(input bit [1:0] sel, input bit [DW-1:0] reg_v,
                                       input bit [DW-1:0] ex_v, input bit [DW-1:0] mem_v);
    bit [DW-1:0] src [4];
    src[0] = reg_v; src[1] = ex_v; src[2] = mem_v; src[3] = reg_v;
    return src[sel];
  endfunction

  function automatic bit exp_hold();
    return reset && LW_Stall && id_valid && !flush;
  endfunction

  always @(posedge clk) begin
    ex_t nxt;
    nxt = '{default: 0};
    if (!reset) begin
      m_stall = 0;
      m_flush = 0;
    end else if (flush) begin
      m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
    end else if (LW_Stall && id_valid) begin
      m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
    end else begin
      nxt.valid = id_valid;
      nxt.a     = pick(ForwardA, rs_data, ex_result, mem_result);
      nxt.b     = pick(ForwardB, rt_data, ex_result, mem_result);
      nxt.imm   = id_imm;
      if (id_valid) begin
        nxt.rw  = id_reg_write;
        nxt.mr  = id_mem_read;
        nxt.mw  = id_mem_write;
        nxt.alu = id_alu_op;
        nxt.wa  = id_write_addr;
      end
    end
    m_ex = nxt;
    started = 1;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("ex_valid",      ex_valid,      m_ex.valid);
      chk("ex_op_a",       ex_op_a,       m_ex.a);
      chk("ex_op_b",       ex_op_b,       m_ex.b);
      chk("ex_imm",        ex_imm,        m_ex.imm);
      chk("ex_reg_write",  ex_reg_write,  m_ex.rw);
      chk("ex_mem_read",   ex_mem_read,   m_ex.mr);
      chk("ex_mem_write",  ex_mem_write,  m_ex.mw);
      chk("ex_alu_op",     ex_alu_op,     m_ex.alu);
      chk("ex_write_addr", ex_write_addr, m_ex.wa);
      chk("stall_cnt",     stall_cnt,     m_stall);
      chk("flush_cnt",     flush_cnt,     m_flush);
      chk("if_id_hold",    if_id_hold,    exp_hold());
    end
  end

  // Inputs change 3 time units after each rising edge, which is well before
  // the falling-edge compare.
  task automatic tick();
    @(posedge clk);
    #3;
    $display("edge t=%0t rst=%0b v=%0b fl=%0b lw=%0b -> ex_v=%0b a=%0h b=%0h wa=%0d sc=%0d fc=%0d",
             $time, reset, id_valid, flush, LW_Stall, ex_valid, ex_op_a, ex_op_b,
             ex_write_addr, stall_cnt, flush_cnt);
  endtask

  task automatic set_idle();
    id_valid = 0; LW_Stall = 0; flush = 0; ForwardA = 0; ForwardB = 0;
    rs_data = 0; rt_data = 0; ex_result = 0; mem_result = 0; id_imm = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_alu_op = 0; id_write_addr = 0;
  endtask

  initial begin
    bit [1:0] fa_tab [4];
    bit [1:0] fb_tab [4];
    bit [DW-1:0] ea_tab [4];
    bit [DW-1:0] eb_tab [4];
    fa_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
    fb_tab = '{2'b00, 2'b10, 2'b01, 2'b11};
    ea_tab = '{32'h11, 32'h33, 32'h44, 32'h11};
    eb_tab = '{32'h22, 32'h44, 32'h33, 32'h22};

    // Reset is held for two edges while flush and stall are both asserted.
    set_idle();
    reset = 0; flush = 1; LW_Stall = 1; id_valid = 1;
    #1;
    chk("lit_hold_in_reset", if_id_hold, 0);
    tick(); tick();
    chk("lit_rst_valid", ex_valid, 0);
    chk("lit_rst_stall", stall_cnt, 0);
    chk("lit_rst_flush", flush_cnt, 0);
    chk("lit_rst_hold", if_id_hold, 0);

    // Forward mux
    set_idle();
    reset = 1; id_valid = 1;
    rs_data = 32'h11; rt_data = 32'h22; ex_result = 32'h33; mem_result = 32'h44;
    for (int i = 0; i < 4; i++) begin
      ForwardA = fa_tab[i]; ForwardB = fb_tab[i];
      tick();
      chk("lit_fwd_a", ex_op_a, ea_tab[i]);
      chk("lit_fwd_b", ex_op_b, eb_tab[i]);
      chk("lit_fwd_valid", ex_valid, 1);
    end

    // Load-use stall, then the held instruction picks up the load value.
    id_write_addr = 5'd7; id_reg_write = 1; LW_Stall = 1; ForwardA = 2'b01;
    #1;
    chk("lit_lu_hold", if_id_hold, 1);
    tick();
    chk("lit_lu_valid", ex_valid, 0);
    chk("lit_lu_wa", ex_write_addr, 0);
    chk("lit_lu_opa", ex_op_a, 0);
    chk("lit_lu_stall", stall_cnt, 1);
    LW_Stall = 0; ForwardA = 2'b10; mem_result = 32'hDEAD;
    tick();
    chk("lit_lu_fwd", ex_op_a, 32'hDEAD);
    chk("lit_lu_valid2", ex_valid, 1);
    chk("lit_lu_wa2", ex_write_addr, 7);

    // When flush and stall arrive together, the flush wins.
    flush = 1; LW_Stall = 1;
    #1;
    chk("lit_fs_hold", if_id_hold, 0);
    tick();
    chk("lit_fs_valid", ex_valid, 0);
    chk("lit_fs_flush", flush_cnt, 1);
    chk("lit_fs_stall", stall_cnt, 1);

    // Saturation: starting from 1, 20 more stalls must stop at 15.
    flush = 0; LW_Stall = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("lit_sat", stall_cnt, 15);
    tick();
    chk("lit_sat_hold", stall_cnt, 15);

    // Reset in the middle of a stall, while a load sits in EX.
    LW_Stall = 0; id_mem_read = 1;
    tick();
    chk("lit_mr_loaded", ex_mem_read, 1);
    reset = 0; LW_Stall = 1;
    tick();
    chk("lit_mr_reset", ex_mem_read, 0);
    chk("lit_mr_stall", stall_cnt, 0);
    chk("lit_mr_flush", flush_cnt, 0);
    reset = 1; set_idle();
    tick();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 31) != 0);
      id_valid      = ($urandom_range(0, 7) != 0);
      flush         = ($urandom_range(0, 7) == 0);
      LW_Stall      = ($urandom_range(0, 3) == 0);
      ForwardA      = 2'($urandom);
      ForwardB      = 2'($urandom);
      rs_data       = $urandom; rt_data = $urandom;
      ex_result     = $urandom; mem_result = $urandom;
      id_imm        = $urandom;
      id_reg_write  = 1'($urandom); id_mem_read = 1'($urandom);
      id_mem_write  = 1'($urandom);
      id_alu_op     = 4'($urandom);
      id_write_addr = 5'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
